// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key presses/gaps and assembles up to five
// dot/dash symbols per character. Optional input filter: MORSE_DEBOUNCE_EN.
//  clk, reset (async, active-high), key (raw level, 1 = pressed)
//  morse[4:0]   1 = dot, 0 = dash, bit 4 = first symbol
//  display[4:0] symbol-present mask, left-justified
//  valid / err  one-cycle pulses; busy = FSM not idle
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 5000000,
  parameter int DASH_UNITS      = 2,
  parameter int CHAR_GAP        = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [4:0] morse,
  output logic [4:0] display,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(UNIT_CYCLES - 1);
  localparam logic [2:0] DASH_D = 3'(DASH_UNITS);
  localparam logic [2:0] GAP_D  = 3'(CHAR_GAP);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic          k1, k2, lvl, lvl_q;
  logic          rise, fall, edge_s, tick;
  logic [PW-1:0] pcnt;
  logic [2:0]    dur;
  logic [4:0]    sh_m, sh_d, mask;
  logic [2:0]    cnt;
  logic          clr, push, v_n, e_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k1 <= 1'b0;
      k2 <= 1'b0;
    end else begin
      k1 <= key;
      k2 <= k1;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          filt;
  logic [DW-1:0] dcnt;

  // level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b0;
      dcnt <= '0;
    end else if (k2 == filt) begin
      dcnt <= '0;
    end else if (dcnt == DMAX) begin
      filt <= k2;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = k2;
`endif

  assign rise   = lvl & ~lvl_q;
  assign fall   = ~lvl & lvl_q;
  assign edge_s = lvl ^ lvl_q;
  // an edge in the same cycle swallows the tick
  assign tick   = (pcnt == PMAX) & ~edge_s;
  assign mask   = 5'b10000 >> cnt;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= 1'b0;
      pcnt  <= '0;
      dur   <= '0;
    end else begin
      lvl_q <= lvl;
      if (edge_s || pcnt == PMAX) pcnt <= '0;
      else                        pcnt <= pcnt + 1'b1;
      if (edge_s)                     dur <= '0;
      else if (tick && dur != 3'd7)   dur <= dur + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    push    = 1'b0;
    v_n     = 1'b0;
    e_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = MARK;
          clr     = 1'b1;
        end
      end
      MARK: begin
        if (fall) begin
          if (cnt < 3'd5) begin
            push    = 1'b1;
            state_n = SPACE;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      SPACE: begin
        if (rise && dur < GAP_D) begin
          state_n = MARK;
        end else if (dur >= GAP_D) begin
          v_n = 1'b1;
          // a press landing on the gap expiry starts the next character
          if (rise) begin
            state_n = MARK;
            clr     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!lvl && dur >= GAP_D) begin
          e_n     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_m    <= '0;
      sh_d    <= '0;
      cnt     <= '0;
      morse   <= '0;
      display <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= v_n;
      err   <= e_n;
      if (v_n) begin
        morse   <= sh_m;
        display <= sh_d;
      end
      if (clr) begin
        sh_m <= '0;
        sh_d <= '0;
        cnt  <= '0;
      end else if (push) begin
        sh_d <= sh_d | mask;
        if (dur < DASH_D) sh_m <= sh_m | mask;
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench for morse_key_decoder: directed table,
// hand-written reset/boundary sequences and randomized characters.
module tb_morse_key_decoder;

  localparam int UNIT = 4;
  localparam int DASH = 2;
  localparam int GAPU = 3;
  localparam int DEB  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [4:0] morse, display;
  logic       valid, err, busy;

  morse_key_decoder #(
    .UNIT_CYCLES(UNIT),
    .DASH_UNITS(DASH),
    .CHAR_GAP(GAPU),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .morse(morse),
    .display(display),
    .valid(valid),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int n_busy  = 0;

  always @(negedge clk) begin
    if (valid) n_valid <= n_valid + 1;
    if (err) n_err <= n_err + 1;
    if (valid && err) n_both <= n_both + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][5:0] len;
    logic [4:0]      m;
    logic [4:0]      d;
    logic            is_err;
  } vec_t;

  function automatic vec_t mk(input int n, input int l0, input int l1,
                              input int l2, input int l3, input int l4,
                              input int l5, input logic [4:0] m,
                              input logic [4:0] d, input logic e);
    vec_t v;
    v.n      = 3'(n);
    v.len[0] = 6'(l0);
    v.len[1] = 6'(l1);
    v.len[2] = 6'(l2);
    v.len[3] = 6'(l3);
    v.len[4] = 6'(l4);
    v.len[5] = 6'(l5);
    v.m      = m;
    v.d      = d;
    v.is_err = e;
    return v;
  endfunction

  task automatic press(input int l, input int g);
    key = 1'b1;
    repeat (l) @(posedge clk);
    #1;
    key = 1'b0;
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic play(input int n, input logic [5:0][5:0] len,
                      input int gin);
    for (int i = 0; i < n; i++)
      press(int'(len[i]), (i == n - 1) ? 20 : gin);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference: a press of L cycles collects (L-1)/UNIT whole units,
  // dash when that reaches DASH; more than five symbols is an error.
  function automatic vec_t model(input int n, input logic [5:0][5:0] len);
    vec_t v;
    v.n      = 3'(n);
    v.len    = len;
    v.m      = '0;
    v.d      = '0;
    v.is_err = (n > 5);
    if (n <= 5) begin
      for (int i = 0; i < n; i++) begin
        v.d[4-i] = 1'b1;
        v.m[4-i] = ((int'(len[i]) - 1) / UNIT) < DASH;
      end
    end
    return v;
  endfunction

  task automatic run_char(input string nm, input vec_t v, input int gin,
                          inout logic [4:0] em, inout logic [4:0] ed);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    play(int'(v.n), v.len, gin);
    chk({nm, " valid"}, n_valid - v0, v.is_err ? 0 : 1);
    chk({nm, " err"}, n_err - e0, v.is_err ? 1 : 0);
    if (!v.is_err) begin
      em = v.m;
      ed = v.d;
    end
    chk({nm, " morse"}, int'(morse), int'(em));
    chk({nm, " display"}, int'(display), int'(ed));
    chk({nm, " busy"}, int'(busy), 0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [4:0]      em, ed;
    logic [5:0][5:0] ln;
    int v0, e0, b0, n;

    tbl[0] = mk(1, 4, 0, 0, 0, 0, 0, 5'b10000, 5'b10000, 1'b0);
    tbl[1] = mk(3, 4, 12, 12, 0, 0, 0, 5'b10000, 5'b11100, 1'b0);
    tbl[2] = mk(6, 4, 4, 4, 4, 4, 4, 5'b10000, 5'b11100, 1'b1);
    tbl[3] = mk(5, 4, 4, 4, 4, 4, 0, 5'b11111, 5'b11111, 1'b0);
    tbl[4] = mk(5, 12, 12, 12, 12, 12, 0, 5'b00000, 5'b11111, 1'b0);
    tbl[5] = mk(1, 8, 0, 0, 0, 0, 0, 5'b10000, 5'b10000, 1'b0);
    tbl[6] = mk(1, 9, 0, 0, 0, 0, 0, 5'b00000, 5'b10000, 1'b0);
    tbl[7] = mk(1, 40, 0, 0, 0, 0, 0, 5'b00000, 5'b10000, 1'b0);
    tbl[8] = mk(4, 12, 4, 12, 4, 0, 0, 5'b01010, 5'b11110, 1'b0);
    tbl[9] = mk(6, 12, 12, 12, 12, 12, 12, 5'b01010, 5'b11110, 1'b1);

    key   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst morse", int'(morse), 0);
    chk("rst display", int'(display), 0);
    chk("rst flags", int'({valid, err, busy}), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    em = '0;
    ed = '0;

    for (int i = 0; i < 10; i++)
      run_char($sformatf("vec%0d", i), tbl[i], 4, em, ed);

    // gap of exactly CHAR_GAP units keeps the character open
    ln = '0;
    ln[0] = 6'd4;
    ln[1] = 6'd4;
    v0 = n_valid;
    play(2, ln, 12);
    chk("gap12 valid", n_valid - v0, 1);
    chk("gap12 morse", int'(morse), 5'b11000);
    chk("gap12 display", int'(display), 5'b11000);

    // async reset mid-press
    key = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midpress busy", int'(busy), 1);
    v0 = n_valid;
    e0 = n_err;
    reset = 1'b1;
    #1;
    chk("async morse", int'(morse), 0);
    chk("async display", int'(display), 0);
    chk("async flags", int'({valid, err, busy}), 0);
    key = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("async no event", (n_valid - v0) + (n_err - e0), 0);

    // reset during the second press of a character
    press(12, 4);
    key = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    key   = 1'b0;
    #1;
    chk("rst2 outputs", int'({morse, display, valid, err, busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst2 no event", (n_valid - v0) + (n_err - e0), 0);
    run_char("after rst", tbl[0], 4, em, ed);

    // two-cycle glitch
    v0 = n_valid;
    b0 = n_busy;
    press(2, 20);
    repeat (4) @(posedge clk);
    #1;
`ifdef MORSE_DEBOUNCE_EN
    chk("glitch valid", n_valid - v0, 0);
    chk("glitch busy", n_busy - b0, 0);
`else
    chk("glitch valid", n_valid - v0, 1);
    chk("glitch morse", int'(morse), 5'b10000);
    chk("glitch display", int'(display), 5'b10000);
`endif

    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(1, 7));
      ln = '0;
      for (int i = 0; i < 6; i++)
        ln[i] = 6'($urandom_range(4, 40));
      run_char($sformatf("rnd%0d", r), model(n, ln),
               int'($urandom_range(4, 12)), em, ed);
    end

    chk("valid+err overlap", n_both, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
